// File: rtl/jj_cntr_sweep_ctrl.sv
// Round-robin sweep sequencer for a loadable up/down counter: grants one of two
// requesters, loads the start value, steps toward the stop value, then holds.
module jj_cntr_sweep_ctrl #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         req0,
  input  logic [W-1:0] start0,
  input  logic [W-1:0] stop0,
  input  logic         req1,
  input  logic [W-1:0] start1,
  input  logic [W-1:0] stop1,
  input  logic [W-1:0] cnt_q,
  output logic         cnt_ld,
  output logic [W-1:0] cnt_d,
  output logic         cnt_up_down,
  output logic [1:0]   gnt,
  output logic         busy,
  output logic         done,
  output logic         done_id
);

  // state | meaning
  // IDLE  | counter held, arbitrating requests
  // LOAD  | counter loaded with latched start value
  // RUN   | counter stepping toward stop value
  // DONE  | counter held, done pulse asserted
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t       state, state_nxt;
  logic         rr, id_r, dir_r;
  logic [W-1:0] start_r, stop_r;
  logic         grant_any, grant_id;

  assign grant_any = req0 | req1;
  assign grant_id  = (req0 & req1) ? rr : req1;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    cnt_ld      = 1'b1;
    cnt_d       = cnt_q;
    cnt_up_down = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any) state_nxt = LOAD;
      end
      LOAD: begin
        cnt_d       = start_r;
        cnt_up_down = dir_r;
        state_nxt   = (start_r == stop_r) ? DONE : RUN;
      end
      RUN: begin
        cnt_up_down = dir_r;
        // Mealy on cnt_q: stop stepping the same cycle the stop value appears
        if (cnt_q != stop_r) begin
          cnt_ld = 1'b0;
        end else begin
          cnt_d     = stop_r;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      gnt     <= 2'b00;
      done    <= 1'b0;
      done_id <= 1'b0;
      rr      <= 1'b0;
      id_r    <= 1'b0;
      start_r <= '0;
      stop_r  <= '0;
      dir_r   <= 1'b0;
    end else begin
      state   <= state_nxt;
      done    <= (state_nxt == DONE);
      done_id <= (state_nxt == DONE) ? id_r : 1'b0;
      if (state == IDLE && grant_any) begin
        gnt     <= grant_id ? 2'b10 : 2'b01;
        id_r    <= grant_id;
        start_r <= grant_id ? start1 : start0;
        stop_r  <= grant_id ? stop1 : stop0;
        dir_r   <= grant_id ? (stop1 >= start1) : (stop0 >= start0);
      end
      if (state == DONE) begin
        gnt <= 2'b00;
        rr  <= ~id_r;
      end
    end
  end

endmodule

// File: tb/tb_jj_cntr_sweep_ctrl.sv
// Bench for jj_cntr_sweep_ctrl: behavioural counter plus a sweep-level predictor
// (grant order, value trajectory, done timing) driven by directed and random sweeps.
module tb_jj_cntr_sweep_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic       req0, req1;
  logic [3:0] start0, stop0, start1, stop1;
  logic [3:0] cnt_q = 4'd0;
  logic       cnt_ld, cnt_up_down;
  logic [3:0] cnt_d;
  logic [1:0] gnt;
  logic       busy, done, done_id;

  int vectors = 0;
  int miscompares = 0;
  int m_rr = 0;

  jj_cntr_sweep_ctrl #(.W(4)) dut (
    .clk(clk), .clr(clr),
    .req0(req0), .start0(start0), .stop0(stop0),
    .req1(req1), .start1(start1), .stop1(stop1),
    .cnt_q(cnt_q), .cnt_ld(cnt_ld), .cnt_d(cnt_d), .cnt_up_down(cnt_up_down),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id)
  );

  always #5 clk = ~clk;

  // the controlled counter: load when ld, else count one step
  always @(posedge clk) begin
    if (cnt_ld) cnt_q <= cnt_d;
    else        cnt_q <= cnt_up_down ? cnt_q + 4'd1 : cnt_q - 4'd1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called just after a negedge with the DUT idle; returns just after a negedge, DUT idle.
  task automatic sweep(input bit r0, input bit r1, input logic [3:0] s0, input logic [3:0] p0,
                       input logic [3:0] s1, input logic [3:0] p1, input bit hold);
    int id, n, last, s, p, exp_q;
    bit up;
    req0 = r0; req1 = r1; start0 = s0; stop0 = p0; start1 = s1; stop1 = p1;
    if (!r0 && !r1) begin
      @(posedge clk); #1;
      chk("nogrant_gnt", gnt, 0);
      chk("nogrant_busy", busy, 0);
      @(negedge clk);
      return;
    end
    id   = (r0 && r1) ? m_rr : (r1 ? 1 : 0);
    s    = id ? int'(s1) : int'(s0);
    p    = id ? int'(p1) : int'(p0);
    up   = (p >= s);
    n    = up ? p - s : s - p;
    last = (n == 0) ? 2 : n + 3;
    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      if (k == 1 && !hold) begin
        req0 = 1'b0; req1 = 1'b0;
        start0 = 4'($urandom); stop0 = 4'($urandom);
        start1 = 4'($urandom); stop1 = 4'($urandom);
      end
      chk("gnt", gnt, id ? 2 : 1);
      chk("busy", busy, 1);
      chk("done", done, (k == last) ? 1 : 0);
      if (k == 1) begin
        chk("ld_load", cnt_ld, 1);
        chk("d_load", cnt_d, s);
        chk("ud_load", cnt_up_down, up);
      end else if (k < last) begin
        exp_q = up ? s + (k - 2) : s - (k - 2);
        chk("q_run", cnt_q, exp_q);
        chk("ld_run", cnt_ld, (k == last - 1) ? 1 : 0);
        chk("ud_run", cnt_up_down, up);
      end else begin
        chk("q_done", cnt_q, p);
        chk("done_id", done_id, id);
        chk("ld_done", cnt_ld, 1);
        chk("d_done", cnt_d, p);
      end
    end
    @(posedge clk); #1;
    chk("gnt_clr", gnt, 0);
    chk("busy_clr", busy, 0);
    chk("done_clr", done, 0);
    m_rr = 1 - id;
    @(negedge clk);
  endtask

  initial begin
    bit found;
    clr = 1'b1;
    req0 = 0; req1 = 0; start0 = 0; stop0 = 0; start1 = 0; stop1 = 0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_done_id", done_id, 0);
    chk("rst_ld", cnt_ld, 1);
    chk("rst_ud", cnt_up_down, 0);
    clr = 1'b0;
    @(negedge clk);

    sweep(1, 0, 4'd3, 4'd9, 4'($urandom), 4'($urandom), 0);
    sweep(0, 1, 4'($urandom), 4'($urandom), 4'd12, 4'd2, 0);

    // both held high: strict alternation 0,1,0,1
    for (int i = 0; i < 4; i++)
      sweep(1, 1, 4'd4, 4'd7, 4'd10, 4'd8, 1);
    req0 = 0; req1 = 0;

    sweep(1, 0, 4'd5, 4'd5, 4'($urandom), 4'($urandom), 0);

    sweep(1, 0, 4'd0, 4'd15, 4'($urandom), 4'($urandom), 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("full_hold_q", cnt_q, 15);
      chk("full_hold_done", done, 0);
    end
    @(negedge clk);

    // reset in the middle of a downward-free upward sweep 2 -> 12
    req0 = 1; start0 = 4'd2; stop0 = 4'd12;
    @(posedge clk); #1;
    req0 = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      if (cnt_q == 4'd6) found = 1;
    end
    chk("rst_reach6", found, 1);
    #3 clr = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_done_id", done_id, 0);
    chk("mid_rst_ld", cnt_ld, 1);
    chk("mid_rst_d", cnt_d, 6);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("mid_rst_q", cnt_q, 6);
      chk("mid_rst_nodone", done, 0);
    end
    @(negedge clk);
    clr = 1'b0;
    m_rr = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_q", cnt_q, 6);
      chk("post_rst_done", done, 0);
    end
    @(negedge clk);

    for (int i = 0; i < 30; i++)
      sweep(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
            4'($urandom), 4'($urandom), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/jj_cntr_sweep_ctrl.md
Name: jj_cntr_sweep_ctrl

Overview:
Two-requester arbiter and sequencer for the team's loadable 4-bit up/down counter (ports d, ld, up_down, qout).
- Each requester asks for a "sweep": the counter is loaded with a start value, then steps one count per cycle toward a stop value, then holds.
- The block grants requesters round-robin and drives the counter's ld/d/up_down.
- It observes qout to detect the end of the sweep and signals completion with a one-cycle done pulse.

Parameters:
W, 4, counter width; must match the controlled counter.

Ports:
clk  input  1  system clock, rising edge
clr  input  1  reset; asynchronous, active-high
req0  input  1  sweep request, requester 0
start0  input  W  sweep start value, requester 0
stop0  input  W  sweep stop value, requester 0
req1  input  1  sweep request, requester 1
start1  input  W  sweep start value, requester 1
stop1  input  W  sweep stop value, requester 1
cnt_q  input  W  counter qout feedback
cnt_ld  output  1  to counter ld
cnt_d  output  W  to counter d
cnt_up_down  output  1  to counter up_down; 1 = up
gnt  output  2  one-hot grant (bit0 = req0); registered
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse at sweep end; registered
done_id  output  1  index of the requester that finished; valid with done

Behaviour:
- States: IDLE, LOAD, RUN, DONE. The counter has no enable, so "hold" means cnt_ld=1 with cnt_d=cnt_q.
- Reset (clr=1, asynchronous):
  - State goes to IDLE.
  - gnt=00, done=0, done_id=0.
  - Round-robin pointer rr=0, so req0 wins the first tie.
  - Internal start_r, stop_r, dir_r are cleared to 0.
- Reset mid-sweep: the sweep is abandoned, no done pulse is generated, and the counter is held at its current value.
- IDLE:
  - Outputs: cnt_ld=1, cnt_d=cnt_q, cnt_up_down=0.
  - Arbitration:
    - If only one req is high, grant that requester.
    - If both are high, grant the requester selected by rr.
    - If neither is high, stay in IDLE.
  - On grant:
    - gnt is set to the granted bit.
    - start/stop of the granted requester are latched into start_r/stop_r.
    - dir_r = (stop >= start), compared unsigned.
    - Next state is LOAD.
- LOAD:
  - Outputs: cnt_ld=1, cnt_d=start_r, cnt_up_down=dir_r.
  - Next state is DONE if start_r==stop_r, else RUN.
- RUN:
  - cnt_up_down=dir_r.
  - If cnt_q != stop_r: cnt_ld=0 (counter steps).
  - If cnt_q == stop_r: cnt_ld=1 and cnt_d=stop_r (hold), next state DONE.
  - This output is Mealy on cnt_q.
- DONE:
  - Hold the counter.
  - done=1 and done_id=granted index for exactly this cycle.
  - gnt clears to 00 on exit.
  - rr is set to the other requester.
  - Next state is IDLE.
- Latency:
  - Grant is registered one cycle after req is seen in IDLE.
  - For a sweep of N = |stop-start| steps: LOAD 1 cycle + RUN N+1 cycles + DONE 1 cycle.
  - Exception: start==stop takes LOAD 1 cycle + DONE 1 cycle.
- Handshake:
  - req is sampled only in IDLE.
  - start/stop are sampled only at grant.
  - Dropping req mid-sweep has no effect; the sweep completes.
  - A req still high after done is treated as a new request.
  - The earliest re-grant is the cycle after DONE.
- Wrap-around cannot occur: direction comes from an unsigned comparison, so the count never passes 0 or 2^W-1.
- The counter's own clr is outside this block's control.

Test Plan:
- Bench has a behavioural counter model. Sweep up: req0, start0=3, stop0=9 → gnt=01; cnt_q runs 3,4,…,9 and holds at 9; done with done_id=0 exactly 9 cycles after LOAD entry; busy low afterwards.
- Sweep down: req1 only, start1=12, stop1=2 → cnt_up_down=0 during RUN; cnt_q runs 12…2 and holds at 2; done_id=1.
- Tie and round-robin: req0 and req1 held high continuously → grant order is 0,1,0,1; done_id alternates; gnt never has two bits set.
- Degenerate sweep: start0=stop0=5 → LOAD then DONE, no RUN state; cnt_q=5; done two cycles after gnt.
- Full range without wrap: start0=0, stop0=15 → 16 values 0..15, then cnt_q holds at 15 for at least 10 cycles after done.
- Async reset mid-RUN: assert clr between clock edges while cnt_q=6 → state, gnt, done and done_id clear immediately; no done pulse; IDLE holds cnt_q at 6.
